// File: rtl/lcd_timing_gen_if.sv
// lcd_timing_gen_if: FIFO read side and panel side of the LCD timing generator
interface lcd_timing_gen_if #(parameter int DATA_W = 16);
  logic lcd_framesync;
  logic lcd_data_requst;
  logic fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic lcd_hsync;
  logic lcd_vsync;
  logic lcd_de;
  logic [DATA_W-1:0] lcd_rgb;
  logic underrun;
  modport master (
    input  lcd_framesync, fifo_empty, fifo_rd_data,
    output lcd_data_requst, lcd_hsync, lcd_vsync, lcd_de, lcd_rgb, underrun
  );
  modport slave (
    output lcd_framesync, fifo_empty, fifo_rd_data,
    input  lcd_data_requst, lcd_hsync, lcd_vsync, lcd_de, lcd_rgb, underrun
  );
endinterface

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: panel HSYNC/VSYNC/DE generator fed from the line-buffer FIFO, with underrun re-align.
// Define LCD_TEST_PATTERN_EN to free-run and show 8 colour bars instead of FIFO data.
module lcd_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 21,
  parameter int DATA_W   = 16
) (
  input logic lcd_clk,
  input logic rst,
  lcd_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int HA = H_SYNC + H_BP;
  localparam int VA = V_SYNC + V_BP;
  localparam logic [HW-1:0] H_SE = HW'(H_SYNC);
  localparam logic [HW-1:0] H_A0 = HW'(HA);
  localparam logic [HW-1:0] H_A1 = HW'(HA + H_ACTIVE);
  localparam logic [HW-1:0] H_R0 = HW'(HA - 1);
  localparam logic [HW-1:0] H_R1 = HW'(HA + H_ACTIVE - 2);
  localparam logic [HW-1:0] H_L  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_SE = VW'(V_SYNC);
  localparam logic [VW-1:0] V_A0 = VW'(VA);
  localparam logic [VW-1:0] V_A1 = VW'(VA + V_ACTIVE);
  localparam logic [VW-1:0] V_L  = VW'(V_TOTAL - 1);
  typedef enum logic {WAIT_SYNC, RUN} state_t;
`ifdef LCD_TEST_PATTERN_EN
  localparam state_t RST_STATE = RUN;
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic [2:0] bar;
`else
  localparam state_t RST_STATE = WAIT_SYNC;
`endif
  state_t state, state_nxt;
  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic starve, starve_nxt;
  logic run, h_act, v_act, h_last, v_last, de_next, req, req_bad;
  logic [DATA_W-1:0] rgb_next;
  always_comb begin
    run = state == RUN;
    h_last = h_cnt == H_L;
    v_last = v_cnt == V_L;
    h_act = h_cnt >= H_A0 && h_cnt < H_A1;
    v_act = v_cnt >= V_A0 && v_cnt < V_A1;
    de_next = run && h_act && v_act;
`ifdef LCD_TEST_PATTERN_EN
    bar = 3'(((32'(h_cnt) - 32'(HA)) * 32'd8) / 32'(H_ACTIVE));
    req = 1'b0;
    req_bad = 1'b0;
    rgb_next = de_next ? DATA_W'(BARS[bar]) : '0;
`else
    req = run && v_act && !starve && h_cnt >= H_R0 && h_cnt <= H_R1;
    req_bad = req && bus.fifo_empty;
    // the pixel whose request hit an empty FIFO is already blanked
    rgb_next = (de_next && !starve) ? bus.fifo_rd_data : '0;
`endif
    state_nxt = run ? ((h_last && v_last && starve) ? WAIT_SYNC : RUN)
                    : (bus.lcd_framesync ? RUN : WAIT_SYNC);
    h_nxt = (!run || h_last) ? '0 : h_cnt + 1'b1;
    v_nxt = !run ? '0 : !h_last ? v_cnt : v_last ? '0 : v_cnt + 1'b1;
    starve_nxt = state_nxt == RUN && (starve || req_bad);
    bus.lcd_data_requst = req;
  end
  always_ff @(posedge lcd_clk or posedge rst) begin
    if (rst) begin
      state <= RST_STATE;
      h_cnt <= '0;
      v_cnt <= '0;
      starve <= 1'b0;
      bus.lcd_hsync <= 1'b1;
      bus.lcd_vsync <= 1'b1;
      bus.lcd_de <= 1'b0;
      bus.lcd_rgb <= '0;
      bus.underrun <= 1'b0;
    end else begin
      state <= state_nxt;
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      starve <= starve_nxt;
      bus.lcd_hsync <= !(run && h_cnt < H_SE);
      bus.lcd_vsync <= !(run && v_cnt < V_SE);
      bus.lcd_de <= de_next;
      bus.lcd_rgb <= rgb_next;
      bus.underrun <= bus.underrun | req_bad;
    end
  end
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: small-timing bench; 14 clks/line, 7 lines/frame, pixel scoreboard on lcd_de.
module tb_lcd_timing_gen;
  localparam int DW = 16;
  logic lcd_clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int passed = 0;
  int idx = 0;
  bit ur = 1'b0;
  logic [DW-1:0] q[$];
  lcd_timing_gen_if #(.DATA_W(DW)) bus();
  lcd_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .DATA_W(DW)
  ) dut (
    .lcd_clk(lcd_clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 lcd_clk = ~lcd_clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
  endtask
  // FIFO with 1-cycle read latency; data is the pixel index within the line
  always @(posedge lcd_clk or posedge rst) begin
    if (rst) begin
      bus.fifo_rd_data <= '0;
      idx <= 0;
    end else if (bus.lcd_data_requst) begin
      if (!bus.fifo_empty) bus.fifo_rd_data <= DW'(idx);
      idx <= idx + 1;
    end else idx <= 0;
  end
  always @(negedge lcd_clk) begin
    if (!rst && bus.lcd_de) begin
      if (q.size() == 0) chk("de_without_expected_pixel", {31'd0, bus.lcd_de}, 32'd0);
      else chk("rgb", 32'(bus.lcd_rgb), 32'(q.pop_front()));
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle", {bus.lcd_hsync, bus.lcd_vsync, bus.lcd_de, bus.lcd_data_requst, bus.underrun},
          {1'b1, 1'b1, 1'b0, 1'b0, ur});
      @(negedge lcd_clk);
    end
  endtask
  task automatic start_frame();
    bus.lcd_framesync = 1'b1;
    @(negedge lcd_clk);
    bus.lcd_framesync = 1'b0;
  endtask
  task automatic push_frame(input int fail_at);
    for (int l = 0; l < 4; l++)
      for (int p = 0; p < 8; p++)
        q.push_back((fail_at == 0 || l * 8 + p + 1 < fail_at) ? DW'(p) : '0);
  endtask
  // k = counter value during this cycle; outputs show the previous counter value
  task automatic run_frames(input int nfr, input int fail_at);
    int nreq, fail_k, c, p;
    bit dead, ereq, ede;
    nreq = 0;
    fail_k = -1;
    for (int k = 0; k < 98 * nfr; k++) begin
      c = k % 98;
      p = (k + 97) % 98;
      dead = fail_k >= 0 && k > fail_k;
      ereq = !dead && c / 14 >= 2 && c / 14 < 6 && c % 14 >= 3 && c % 14 <= 10;
      ede = p / 14 >= 2 && p / 14 < 6 && p % 14 >= 4 && p % 14 < 12;
      chk("timing", {bus.lcd_hsync, bus.lcd_vsync, bus.lcd_de, bus.lcd_data_requst, bus.underrun},
          {p % 14 >= 2, p / 14 >= 1, ede, ereq, ur | dead});
      if (ereq) begin
        nreq++;
        if (nreq == fail_at) begin
          fail_k = k;
          bus.fifo_empty = 1'b1;
        end
      end
      bus.lcd_framesync = fail_at == 0 && (k % 98 == 96 || k == 119);
      @(negedge lcd_clk);
    end
    if (fail_k >= 0) ur = 1'b1;
    bus.fifo_empty = 1'b0;
  endtask
  initial begin
    bus.lcd_framesync = 1'b0;
    bus.fifo_empty = 1'b0;
    repeat (3) @(negedge lcd_clk);
    rst = 1'b0;
    idle(100);
    push_frame(0);
    push_frame(0);
    start_frame();
    run_frames(2, 0);
    push_frame(11);
    run_frames(1, 11);
    chk("underrun_sticky", {31'd0, bus.underrun}, 32'd1);
    idle(30);
    push_frame(0);
    start_frame();
    run_frames(1, 0);
    for (int i = 0; i < 8; i++) q.push_back(DW'(i));
    repeat (33) @(negedge lcd_clk);
    chk("pre_rst_de", {31'd0, bus.lcd_de}, 32'd1);
    chk("pre_rst_req", {31'd0, bus.lcd_data_requst}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_outputs", {bus.lcd_hsync, bus.lcd_vsync, bus.lcd_de, bus.lcd_data_requst, bus.underrun}, 5'b11000);
    chk("rst_rgb", 32'(bus.lcd_rgb), 32'd0);
    chk("rst_pixels_left", q.size(), 7);
    q.delete();
    ur = 1'b0;
    @(negedge lcd_clk);
    rst = 1'b0;
    idle(30);
    push_frame(0);
    start_frame();
    run_frames(1, 0);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
